int_arbiter: RTL and testbench
==============================

# int_arbiter

Interrupt source arbiter and sequencer placed in front of the core-local interrupt manager. It collects up to eight peripheral interrupt lines (timer, UART, GPIO, …), latches and masks them, and selects one winner. It presents the winner on the core's `INT_BUS` interrupt-flag input and holds it there until trap entry. It then tracks the in-service source until software signals completion through a claim/complete register.

## Interface
- `NUM_SRC`, default 8: number of interrupt sources, range 1..8.
- `ID_W`, default 3: source-ID width, equal to ceil(log2(NUM_SRC)) with a minimum of 1.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous, active-low.
- `irq_i` in NUM_SRC: raw peripheral requests, synchronous to `clk`.
- `int_taken_i` in 1: one-cycle pulse when the interrupt manager enters an asynchronous trap. It is generated when the manager writes mcause and is never pulsed on mret.
- `cfg_we_i` in 1: configuration write strobe.
- `cfg_addr_i` in 2: register select.
- `cfg_data_i` in 32: write data.
- `cfg_rdata_o` out 32: read data, a combinational mux on `cfg_addr_i`.
- `int_flag_o` out 8 (`INT_BUS`): one-hot of the presented source, zero-extended above NUM_SRC; all zero when nothing is presented.

## Operation
- Registers:
  - 0 ENABLE: read/write, reset 0.
  - 1 PENDING: read; writing 1 clears the bit, edge sources only.
  - 2 EDGE: read/write, reset 0. Bit value 1 selects edge mode, 0 selects level mode.
  - 3 CLAIM: read returns {bit31 = in-service valid, bits[ID_W-1:0] = id}. Write is "complete" and is honoured only in SERVICE with `cfg_data_i[ID_W-1:0]` == claimed id; otherwise it is ignored.
- Pending:
  - Edge source: `pending |= irq_i & ~irq_q`. `irq_q` is the previous-cycle sample of `irq_i`.
  - Level source: `pending = irq_i` (registered).
  - If a set and a W1C clear hit the same bit in the same cycle, the set wins.
- Candidate set: `pending & ENABLE`.
- Winner selection is done by sub-module `int_arb_pick`. The default is fixed priority, where the lowest index wins.
- State machine (3 states):
  - IDLE: if the candidate set is non-zero, latch `pres_id` = winner and go to PRESENT.
  - PRESENT: `int_flag_o` = 1 << `pres_id`.
    - On `int_taken_i`, go to SERVICE. Copy `pres_id` to `claim_id`. Clear `pending[pres_id]` if the source is edge mode.
    - If `pending[pres_id] & ENABLE[pres_id]` drops before `int_taken_i`, withdraw: go to IDLE and drop the flag. If both happen in the same cycle, `int_taken_i` wins.
  - SERVICE: `int_flag_o` = 0; all other sources are held off (no nesting). A valid complete write returns the state to IDLE.
- `int_taken_i` is ignored in IDLE and SERVICE.
- A level source that is still high after complete re-arbitrates normally.

## Timing
- Reset state: state = IDLE; ENABLE, EDGE, PENDING, `irq_q`, `pres_id` and `claim_id` all 0; `int_flag_o` = 0; `cfg_rdata_o` reflects the zeroed registers.
- `int_flag_o` is driven only from registered state and `pres_id`; there is no combinational path from `irq_i`.
- Latency from `irq_i` first sampled high (edge k) to `int_flag_o`: pending becomes visible after edge k, and the flag is visible after edge k+1.
- Latency from an ENABLE write (edge k) to flag, with the source already pending: flag is visible after edge k+1.
- `int_taken_i` at edge k: flag reads 0 and CLAIM valid reads 1 after edge k.
- Complete write at edge k: state is IDLE after edge k; the next flag can appear after edge k+1.
- Reset asserted in any state aborts everything within one edge, including a pending complete.

## Configuration
- `INT_ARB_ROUND_ROBIN_EN` defined: `int_arb_pick` uses rotating priority. The search starts at `last_id+1` and wraps modulo NUM_SRC. `last_id` resets to NUM_SRC-1 and updates to `pres_id` on `int_taken_i`.
- `INT_ARB_ROUND_ROBIN_EN` undefined: fixed priority, lowest index wins, and there is no pointer register.

## Structure
- The shared defines file holds: register address constants (`INT_ARB_ENABLE`/`PENDING`/`EDGE`/`CLAIM`), state encodings (one-hot, 3 bits), and reuse of `INT_BUS`/`INT_NONE`.
- One sub-module, `int_arb_pick`:
  - Inputs: candidate vector, plus the pointer under the macro.
  - Outputs: `valid` and `id`.
  - Contains the only configuration-dependent logic.

## Test plan
- Reset: hold `rst` = 0 for 3 cycles with `irq_i` = 8'hFF. Required: `int_flag_o` = 0, all registers read 0, CLAIM = 0.
- Edge flow: ENABLE = 8'h04, EDGE = 8'h04, pulse `irq_i[2]` for 1 cycle.
  - Flag reads 8'h04 two edges later.
  - `int_taken_i` pulse: flag = 0, CLAIM = 32'h8000_0002, PENDING[2] = 0.
  - Write CLAIM = 2: state returns to IDLE.
- Priority: enable sources 1 and 5 (level), raise both together.
  - Fixed priority: 8'h02 first; after take and complete, 8'h20.
  - Round-robin: after servicing 1, re-raise both; 8'h20 wins.
- Level gating: hold `irq_i[3]` high with ENABLE = 0. Required: no flag for 10 cycles. Write ENABLE = 8'h08: flag = 8'h08 one edge later.
- Withdraw: in PRESENT for source 3, clear ENABLE. Required: flag = 0 next edge; a later `int_taken_i` is ignored and CLAIM valid stays 0.
- Robustness:
  - In SERVICE with claim id 2, writing CLAIM = 5 is ignored and SERVICE holds.
  - Asserting `rst` low mid-SERVICE gives IDLE and all registers 0 after one edge.

Source files
------------

// File: rtl/int_arbiter_pkg.sv
// Shared constants for the interrupt arbiter: register map, one-hot FSM encoding
// and the core's INT_BUS flag type.
package int_arbiter_pkg;

  localparam int INT_BUS_W = 8;
  typedef logic [INT_BUS_W-1:0] int_bus_t;
  localparam int_bus_t INT_NONE = '0;

  localparam logic [1:0] INT_ARB_ENABLE  = 2'd0;
  localparam logic [1:0] INT_ARB_PENDING = 2'd1;
  localparam logic [1:0] INT_ARB_EDGE    = 2'd2;
  localparam logic [1:0] INT_ARB_CLAIM   = 2'd3;

  typedef enum logic [2:0] {
    ARB_IDLE    = 3'b001,
    ARB_PRESENT = 3'b010,
    ARB_SERVICE = 3'b100
  } arb_state_t;

endpackage

// File: rtl/int_arb_pick.sv
// Winner selection over the candidate vector. Fixed priority (lowest index) by default;
// rotating priority starting after last_id when INT_ARB_ROUND_ROBIN_EN is defined.
module int_arb_pick
  import int_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 3
) (
  input  logic [NUM_SRC-1:0] cand,
`ifdef INT_ARB_ROUND_ROBIN_EN
  input  logic [ID_W-1:0]    last_id,
`endif
  output logic               valid,
  output logic [ID_W-1:0]    id
);

  assign valid = |cand;

`ifdef INT_ARB_ROUND_ROBIN_EN
  // Each source's distance from the slot after last_id; the nearest candidate wins.
  always_comb begin
    int dist;
    int best;
    id   = '0;
    dist = 0;
    best = NUM_SRC;
    for (int i = 0; i < NUM_SRC; i++) begin
      dist = i - int'(last_id) - 1;
      if (dist < 0) dist = dist + NUM_SRC;
      if (cand[i] && (dist < best)) begin
        best = dist;
        id   = ID_W'(i);
      end
    end
  end
`else
  always_comb begin
    id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand[i]) id = ID_W'(i);
    end
  end
`endif

endmodule

// File: rtl/int_arbiter.sv
// Interrupt source arbiter: latches/masks up to eight sources, presents one winner on
// INT_BUS until trap entry, then holds it in service until a matching complete write.
// Optional feature: INT_ARB_ROUND_ROBIN_EN selects rotating priority.
module int_arbiter
  import int_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_i,
  input  logic               int_taken_i,
  input  logic               cfg_we_i,
  input  logic [1:0]         cfg_addr_i,
  input  logic [31:0]        cfg_data_i,
  output logic [31:0]        cfg_rdata_o,
  output int_bus_t           int_flag_o
);

  arb_state_t          state_reg, state_next;
  logic [NUM_SRC-1:0]  enable_reg, edge_reg, pending_reg, pending_next, irq_q_reg;
  logic [ID_W-1:0]     pres_id_reg, claim_id_reg;

  logic [NUM_SRC-1:0]  cand, pres_mask, rise, w1c_clr, take_clr;
  logic                pick_valid;
  logic [ID_W-1:0]     pick_id;
  logic                wr_enable, wr_pending, wr_edge, wr_claim;
  logic                complete_hit, take_fire, pres_live;
  logic                unused_data;

  assign unused_data = ^cfg_data_i[31:NUM_SRC];

  assign wr_enable  = cfg_we_i && (cfg_addr_i == INT_ARB_ENABLE);
  assign wr_pending = cfg_we_i && (cfg_addr_i == INT_ARB_PENDING);
  assign wr_edge    = cfg_we_i && (cfg_addr_i == INT_ARB_EDGE);
  assign wr_claim   = cfg_we_i && (cfg_addr_i == INT_ARB_CLAIM);

  assign cand         = pending_reg & enable_reg;
  assign pres_mask    = NUM_SRC'(1) << pres_id_reg;
  assign pres_live    = |(cand & pres_mask);
  assign complete_hit = wr_claim && (state_reg == ARB_SERVICE)
                        && (cfg_data_i[ID_W-1:0] == claim_id_reg);

  assign rise     = irq_i & ~irq_q_reg;
  assign w1c_clr  = wr_pending ? cfg_data_i[NUM_SRC-1:0] : '0;
  assign take_clr = take_fire ? pres_mask : '0;

  // Edge sources accumulate (a fresh edge beats any clear); level sources follow the line.
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_pend
      assign pending_next[gi] = edge_reg[gi]
          ? ((pending_reg[gi] & ~w1c_clr[gi] & ~take_clr[gi]) | rise[gi])
          : irq_i[gi];
    end
  endgenerate

`ifdef INT_ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0] last_id_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_id_reg <= ID_W'(NUM_SRC - 1);
    end else if (take_fire) begin
      last_id_reg <= pres_id_reg;
    end
  end

  int_arb_pick #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) u_pick (
    .cand    (cand),
    .last_id (last_id_reg),
    .valid   (pick_valid),
    .id      (pick_id)
  );
`else
  int_arb_pick #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) u_pick (
    .cand  (cand),
    .valid (pick_valid),
    .id    (pick_id)
  );
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= ARB_IDLE;
      enable_reg   <= '0;
      edge_reg     <= '0;
      pending_reg  <= '0;
      irq_q_reg    <= '0;
      pres_id_reg  <= '0;
      claim_id_reg <= '0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      irq_q_reg   <= irq_i;
      if (wr_enable) enable_reg <= cfg_data_i[NUM_SRC-1:0];
      if (wr_edge)   edge_reg   <= cfg_data_i[NUM_SRC-1:0];
      if ((state_reg == ARB_IDLE) && pick_valid) pres_id_reg <= pick_id;
      if (take_fire) claim_id_reg <= pres_id_reg;
    end
  end

  // Trap entry beats withdrawal when both land in the same cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ARB_IDLE:    if (pick_valid) state_next = ARB_PRESENT;
      ARB_PRESENT: begin
        if (int_taken_i)     state_next = ARB_SERVICE;
        else if (!pres_live) state_next = ARB_IDLE;
      end
      ARB_SERVICE: if (complete_hit) state_next = ARB_IDLE;
      default:     state_next = ARB_IDLE;
    endcase
  end

  always_comb begin
    int_flag_o = INT_NONE;
    take_fire  = 1'b0;
    if (state_reg == ARB_PRESENT) begin
      int_flag_o = int_bus_t'(pres_mask);
      take_fire  = int_taken_i;
    end
  end

  always_comb begin
    cfg_rdata_o = '0;
    case (cfg_addr_i)
      INT_ARB_ENABLE:  cfg_rdata_o = 32'(enable_reg);
      INT_ARB_PENDING: cfg_rdata_o = 32'(pending_reg);
      INT_ARB_EDGE:    cfg_rdata_o = 32'(edge_reg);
      INT_ARB_CLAIM: begin
        cfg_rdata_o     = 32'(claim_id_reg);
        cfg_rdata_o[31] = (state_reg == ARB_SERVICE);
      end
      default:         cfg_rdata_o = '0;
    endcase
  end

endmodule

// File: tb/tb_int_arbiter.sv
// Directed plus randomized bench for int_arbiter against a per-source behavioural model.
module tb_int_arbiter;

  localparam int N = 8;

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic [7:0]  irq   = 8'h00;
  logic        taken = 1'b0;
  logic        we    = 1'b0;
  logic [1:0]  addr  = 2'd0;
  logic [31:0] data  = 32'h0;
  logic [31:0] rdata;
  logic [7:0]  flag;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  int_arbiter #(.NUM_SRC(8), .ID_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .irq_i       (irq),
    .int_taken_i (taken),
    .cfg_we_i    (we),
    .cfg_addr_i  (addr),
    .cfg_data_i  (data),
    .cfg_rdata_o (rdata),
    .int_flag_o  (flag)
  );

  // Model: mode 0 = nothing presented, 1 = presenting m_pres, 2 = in service for m_claim.
  logic [7:0] m_en = 8'h0, m_edge = 8'h0, m_pend = 8'h0, m_irq_q = 8'h0;
  int m_mode = 0, m_pres = 0, m_claim = 0, m_last = N - 1;

`ifdef INT_ARB_ROUND_ROBIN_EN
  localparam logic [7:0] PRI_FIRST  = 8'h20;
  localparam logic [7:0] PRI_SECOND = 8'h02;
  localparam int         PRI_ID1    = 5;
`else
  localparam logic [7:0] PRI_FIRST  = 8'h02;
  localparam logic [7:0] PRI_SECOND = 8'h02;
  localparam int         PRI_ID1    = 1;
`endif

  function automatic bit has(logic [7:0] v, int j);
    logic [7:0] s;
    s = v >> j;
    return s[0];
  endfunction

  function automatic int pick(logic [7:0] c, int last);
`ifdef INT_ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= N; k++) begin
      if (has(c, (last + k) % N)) return (last + k) % N;
    end
`else
    for (int j = 0; j < N; j++) begin
      if (has(c, j)) return j;
    end
`endif
    return -1;
  endfunction

  task automatic model_step();
    logic [7:0] np;
    bit keep, took;
    int w, nm;
    if (!rst) begin
      m_en = 0; m_edge = 0; m_pend = 0; m_irq_q = 0;
      m_mode = 0; m_pres = 0; m_claim = 0; m_last = N - 1;
      return;
    end
    took = (m_mode == 1) && taken;
    for (int i = 0; i < N; i++) begin
      if (has(m_edge, i)) begin
        keep = has(m_pend, i);
        if (we && addr == 2'd1 && data[i]) keep = 1'b0;
        if (took && i == m_pres) keep = 1'b0;
        np[i] = keep | (irq[i] & ~m_irq_q[i]);
      end else begin
        np[i] = irq[i];
      end
    end
    nm = m_mode;
    case (m_mode)
      0: begin
        w = pick(m_pend & m_en, m_last);
        if (w >= 0) begin nm = 1; m_pres = w; end
      end
      1: begin
        if (taken) begin nm = 2; m_claim = m_pres; m_last = m_pres; end
        else if (!(has(m_pend, m_pres) && has(m_en, m_pres))) nm = 0;
      end
      default: if (we && addr == 2'd3 && data[2:0] == 3'(m_claim)) nm = 0;
    endcase
    m_mode  = nm;
    m_pend  = np;
    m_irq_q = irq;
    if (we && addr == 2'd0) m_en   = data[7:0];
    if (we && addr == 2'd2) m_edge = data[7:0];
  endtask

  function automatic logic [7:0] exp_flag();
    return (m_mode == 1) ? (8'h01 << m_pres) : 8'h00;
  endfunction

  function automatic logic [31:0] exp_rdata(logic [1:0] a);
    case (a)
      2'd0:    return {24'h0, m_en};
      2'd1:    return {24'h0, m_pend};
      2'd2:    return {24'h0, m_edge};
      default: return {(m_mode == 2), 28'h0, 3'(m_claim)};
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check("flag_model", {24'h0, flag}, {24'h0, exp_flag()});
  endtask

  task automatic wr(logic [1:0] a, logic [31:0] d);
    $display("wr addr=%0d data=%h", a, d);
    we = 1'b1; addr = a; data = d;
    cyc();
    we = 1'b0; data = 32'h0;
  endtask

  task automatic take();
    $display("int_taken pulse");
    taken = 1'b1;
    cyc();
    taken = 1'b0;
  endtask

  task automatic rd(logic [1:0] a, string tag, logic [31:0] exp);
    addr = a;
    #1;
    check(tag, rdata, exp);
    check({tag, "_model"}, rdata, exp_rdata(a));
  endtask

  initial begin
    // Reset with every line asserted.
    rst = 1'b0; irq = 8'hFF;
    repeat (3) cyc();
    check("rst_flag", {24'h0, flag}, 32'h0);
    rd(2'd0, "rst_enable", 32'h0);
    rd(2'd1, "rst_pending", 32'h0);
    rd(2'd2, "rst_edge", 32'h0);
    rd(2'd3, "rst_claim", 32'h0);
    rst = 1'b1; irq = 8'h00;
    cyc();

    // Edge flow on source 2.
    wr(2'd0, 32'h04);
    wr(2'd2, 32'h04);
    irq = 8'h04; cyc(); irq = 8'h00;
    $display("pulse irq[2]");
    check("edge_flag_early", {24'h0, flag}, 32'h0);
    rd(2'd1, "edge_pending_set", 32'h04);
    cyc();
    check("edge_flag", {24'h0, flag}, 32'h04);
    take();
    check("edge_taken_flag", {24'h0, flag}, 32'h0);
    rd(2'd3, "edge_claim", 32'h8000_0002);
    rd(2'd1, "edge_pending_clr", 32'h0);
    wr(2'd3, 32'h2);
    rd(2'd3, "edge_complete", 32'h0000_0002);

    // Priority between level sources 1 and 5.
    wr(2'd2, 32'h00);
    wr(2'd0, 32'h22);
    irq = 8'h22; cyc(); cyc();
    check("pri_first", {24'h0, flag}, {24'h0, PRI_FIRST});
    take();
    wr(2'd3, 32'(PRI_ID1));
    cyc();
    check("pri_second", {24'h0, flag}, {24'h0, PRI_SECOND});
    take();
    irq = 8'h20;
    wr(2'd3, 32'h1);
    cyc();
    check("pri_third", {24'h0, flag}, 32'h20);
    take();
    irq = 8'h00;
    wr(2'd3, 32'h5);
    cyc(); cyc();

    // Level gating by ENABLE.
    wr(2'd0, 32'h00);
    irq = 8'h08;
    repeat (10) cyc();
    check("gate_noflag", {24'h0, flag}, 32'h0);
    wr(2'd0, 32'h08);
    cyc();
    check("gate_flag", {24'h0, flag}, 32'h08);

    // Withdraw by clearing ENABLE while presenting source 3.
    wr(2'd0, 32'h00);
    cyc();
    check("withdraw_flag", {24'h0, flag}, 32'h0);
    take();
    addr = 2'd3; #1;
    check("withdraw_claim_valid", {31'h0, rdata[31]}, 32'h0);
    irq = 8'h00;
    cyc();

    // Mismatched complete is ignored; reset aborts service and a simultaneous complete.
    wr(2'd0, 32'h04);
    irq = 8'h04; cyc(); cyc();
    check("rob_flag", {24'h0, flag}, 32'h04);
    take();
    wr(2'd3, 32'h5);
    rd(2'd3, "rob_bad_complete", 32'h8000_0002);
    rst = 1'b0; we = 1'b1; addr = 2'd3; data = 32'h2;
    cyc();
    we = 1'b0; data = 32'h0;
    check("rob_rst_flag", {24'h0, flag}, 32'h0);
    rd(2'd0, "rob_rst_enable", 32'h0);
    rd(2'd1, "rob_rst_pending", 32'h0);
    rd(2'd2, "rob_rst_edge", 32'h0);
    rd(2'd3, "rob_rst_claim", 32'h0);
    rst = 1'b1; irq = 8'h00;
    cyc();

    // Randomized traffic against the model.
    for (int t = 0; t < 600; t++) begin
      if ($urandom_range(0, 3) == 0) irq = 8'($urandom);
      taken = ($urandom_range(0, 2) == 0);
      we    = ($urandom_range(0, 3) == 0);
      addr  = 2'($urandom);
      data  = ($urandom_range(0, 1) == 1) ? 32'(m_claim) : $urandom;
      rst   = ($urandom_range(0, 149) != 0);
      cyc();
      taken = 1'b0; we = 1'b0; rst = 1'b1;
      addr = 2'($urandom);
      #1;
      check("rand_rdata", rdata, exp_rdata(addr));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
